time_tmr_end: RTL and testbench

TIME_TMR_END -- requirements
Module: time_tmr_end

---
 rtl/time_tmr_pkg.sv | 24 ++
 rtl/time_tmr_voter.sv | 43 ++++
 rtl/time_tmr_end.sv | 155 +++++++++++++++
 tb/tb_time_tmr_end.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_tmr_pkg.sv
// -----------------------------------------------------------------------------
// time_tmr_pkg
// Shared constants and id-field helpers for the temporal TMR start/end blocks.
// An element id is split as:
//   id[ReplicaIdxWidth-1:0]  replica index (0,1,2)
//   id[IDSize-1:2]           element sequence number
// Helpers take and return 32-bit values; callers cast to their own widths.
// -----------------------------------------------------------------------------
package time_tmr_pkg;

    localparam int unsigned NumReplicas     = 3;
    localparam int unsigned ReplicaIdxWidth = 2;

    // Replica index field, zero-extended to 32 bits.
    function automatic logic [31:0] id_replica(input logic [31:0] id);
        return id & 32'((1 << ReplicaIdxWidth) - 1);
    endfunction

    // Sequence number field, right-aligned.
    function automatic logic [31:0] id_seq(input logic [31:0] id);
        return id >> ReplicaIdxWidth;
    endfunction

endpackage

// File: rtl/time_tmr_voter.sv
// -----------------------------------------------------------------------------
// time_tmr_voter
// Combinational 2-of-3 vote over a window of three entries.
// Ports:
//   i_data/i_seq/i_rep/i_vld : window entries, index 0 is the newest
//   o_match                  : at least two valid entries agree on seq and data
//   o_data/o_seq             : the agreeing value (meaningful when o_match)
//   o_unanimous              : all three agree and carry replicas 0,1,2
// -----------------------------------------------------------------------------
module time_tmr_voter
    import time_tmr_pkg::*;
#(
    parameter type         DataType = logic [7:0],
    parameter int unsigned SeqW     = 3
) (
    input  DataType                     i_data [NumReplicas],
    input  logic [SeqW-1:0]             i_seq  [NumReplicas],
    input  logic [ReplicaIdxWidth-1:0]  i_rep  [NumReplicas],
    input  logic                        i_vld  [NumReplicas],
    output logic                        o_match,
    output DataType                     o_data,
    output logic [SeqW-1:0]             o_seq,
    output logic                        o_unanimous
);

    logic       w_m01, w_m02, w_m12;
    logic [2:0] w_rep_set;

    assign w_m01 = i_vld[0] & i_vld[1] & (i_seq[0] == i_seq[1]) & (i_data[0] == i_data[1]);
    assign w_m02 = i_vld[0] & i_vld[2] & (i_seq[0] == i_seq[2]) & (i_data[0] == i_data[2]);
    assign w_m12 = i_vld[1] & i_vld[2] & (i_seq[1] == i_seq[2]) & (i_data[1] == i_data[2]);

    // At most one distinct agreeing value can exist in three entries,
    // so entry 0 is the answer whenever it is part of any matching pair.
    assign o_match = w_m01 | w_m02 | w_m12;
    assign o_data  = (w_m01 | w_m02) ? i_data[0] : i_data[1];
    assign o_seq   = (w_m01 | w_m02) ? i_seq[0]  : i_seq[1];

    // One-hot OR of replica indices; all three present gives 3'b111.
    assign w_rep_set   = (3'b001 << i_rep[0]) | (3'b001 << i_rep[1]) | (3'b001 << i_rep[2]);
    assign o_unanimous = w_m01 & w_m12 & (w_rep_set == 3'b111);

endmodule

// File: rtl/time_tmr_end.sv
// -----------------------------------------------------------------------------
// time_tmr_end
// Temporal TMR end stage: collects three time-multiplexed replicas of each
// element, votes 2-of-3, forwards one result per element downstream.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   enable_i                 redundancy enable (0: combinational pass-through)
//   data_i/id_i/valid_i      upstream payload, id {seq, replica}, valid
//   ready_o                  upstream ready
//   data_o/valid_o/ready_i   downstream handshake
//   lock_o                   hold the upstream arbiter on this source
//   fault_detected_o         one-cycle fault pulse
// Optional: define TIME_TMR_END_ASSERTIONS_EN to include runtime assertions.
// -----------------------------------------------------------------------------
module time_tmr_end
    import time_tmr_pkg::*;
#(
    parameter type         DataType    = logic [7:0],
    parameter int unsigned IDSize      = 5,
    parameter int unsigned LockTimeout = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              lock_o,
    output logic              fault_detected_o
);

    localparam int unsigned SeqW = IDSize - ReplicaIdxWidth;
    localparam int unsigned CntW = $clog2(LockTimeout + 1);

    // The vote window is the incoming entry plus the two previous accepts;
    // the oldest of the three is dropped by the shift, so only two are stored.
    DataType                    r_win_data [2];
    logic [SeqW-1:0]            r_win_seq  [2];
    logic [ReplicaIdxWidth-1:0] r_win_rep  [2];
    logic                       r_win_vld  [2];

    logic                       r_valid;
    DataType                    r_data;
    logic                       r_last_vld;
    logic [SeqW-1:0]            r_last_seq;
    logic                       r_lock_rep;
    logic [CntW-1:0]            r_cnt;
    logic                       r_fault;

    logic [SeqW-1:0]            w_in_seq;
    logic [ReplicaIdxWidth-1:0] w_in_rep;
    DataType                    w_nxt_data [NumReplicas];
    logic [SeqW-1:0]            w_nxt_seq  [NumReplicas];
    logic [ReplicaIdxWidth-1:0] w_nxt_rep  [NumReplicas];
    logic                       w_nxt_vld  [NumReplicas];
    logic                       w_match, w_unanimous;
    DataType                    w_vote_data;
    logic [SeqW-1:0]            w_vote_seq;
    logic                       w_accept, w_load, w_fault_rep2, w_timeout;

    assign w_in_seq = SeqW'(id_seq(32'(id_i)));
    assign w_in_rep = ReplicaIdxWidth'(id_replica(32'(id_i)));

    assign w_nxt_data[0] = data_i;        assign w_nxt_seq[0] = w_in_seq;
    assign w_nxt_rep[0]  = w_in_rep;      assign w_nxt_vld[0] = 1'b1;
    assign w_nxt_data[1] = r_win_data[0]; assign w_nxt_seq[1] = r_win_seq[0];
    assign w_nxt_rep[1]  = r_win_rep[0];  assign w_nxt_vld[1] = r_win_vld[0];
    assign w_nxt_data[2] = r_win_data[1]; assign w_nxt_seq[2] = r_win_seq[1];
    assign w_nxt_rep[2]  = r_win_rep[1];  assign w_nxt_vld[2] = r_win_vld[1];

    time_tmr_voter #(.DataType(DataType), .SeqW(SeqW)) u_voter (
        .i_data      (w_nxt_data),
        .i_seq       (w_nxt_seq),
        .i_rep       (w_nxt_rep),
        .i_vld       (w_nxt_vld),
        .o_match     (w_match),
        .o_data      (w_vote_data),
        .o_seq       (w_vote_seq),
        .o_unanimous (w_unanimous)
    );

    assign w_accept     = enable_i & valid_i & ready_o;
    // Agreement on an already emitted sequence is a duplicate or late replica.
    assign w_load       = w_accept & w_match & (~r_last_vld | (w_vote_seq != r_last_seq));
    assign w_fault_rep2 = w_accept & (w_in_rep == 2'd2) & ~w_unanimous;
    // Fires on the edge where the counter would reach LockTimeout.
    assign w_timeout    = r_lock_rep & ~w_accept & (r_cnt == CntW'(LockTimeout - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                r_win_data[i] <= '0;
                r_win_seq[i]  <= '0;
                r_win_rep[i]  <= '0;
                r_win_vld[i]  <= 1'b0;
            end
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_last_vld <= 1'b0;
            r_last_seq <= '0;
            r_lock_rep <= 1'b0;
            r_cnt      <= '0;
            r_fault    <= 1'b0;
        end else if (!enable_i) begin
            r_win_vld[0] <= 1'b0;
            r_win_vld[1] <= 1'b0;
            r_valid      <= 1'b0;
            r_last_vld   <= 1'b0;
            r_lock_rep   <= 1'b0;
            r_cnt        <= '0;
            r_fault      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_win_data[1] <= r_win_data[0]; r_win_data[0] <= data_i;
                r_win_seq[1]  <= r_win_seq[0];  r_win_seq[0]  <= w_in_seq;
                r_win_rep[1]  <= r_win_rep[0];  r_win_rep[0]  <= w_in_rep;
                r_win_vld[1]  <= r_win_vld[0];  r_win_vld[0]  <= 1'b1;
                r_cnt         <= '0;
                r_lock_rep    <= (w_in_rep != 2'd2);
            end else begin
                if (r_cnt != CntW'(LockTimeout)) r_cnt <= r_cnt + 1'b1;
                if (w_timeout) r_lock_rep <= 1'b0;
            end
            // Load has priority so a new result can replace one draining now.
            if (w_load) begin
                r_valid    <= 1'b1;
                r_data     <= w_vote_data;
                r_last_vld <= 1'b1;
                r_last_seq <= w_vote_seq;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            r_fault <= w_fault_rep2 | w_timeout;
        end
    end

    assign ready_o          = enable_i ? (~r_valid | ready_i) : ready_i;
    assign valid_o          = enable_i ? r_valid : valid_i;
    assign data_o           = enable_i ? r_data  : data_i;
    assign lock_o           = enable_i & r_lock_rep;
    assign fault_detected_o = enable_i & r_fault;

`ifdef TIME_TMR_END_ASSERTIONS_EN
    a_params: assert property (@(posedge clk_i) (IDSize >= 3) && (LockTimeout >= 1));
    a_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (enable_i && r_valid && !ready_i) |=> (!enable_i || (r_valid && $stable(r_data))));
    a_rep: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (enable_i && valid_i) |-> (w_in_rep != 2'd3));
`endif

endmodule

// File: tb/tb_time_tmr_end.sv
// Bench for time_tmr_end: directed scenarios plus randomized traffic, checked
// each cycle against a queue-based reference model of the voting rules.
module tb_time_tmr_end;
    localparam int LT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1, vi = 1'b0, rdy = 1'b0;
    logic [7:0] di = '0;
    logic [4:0] idi = '0;
    logic       ready_o, valid_o, lock_o, fault_o;
    logic [7:0] data_o;

    time_tmr_end dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .data_i(di), .id_i(idi), .valid_i(vi), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(rdy),
        .lock_o(lock_o), .fault_detected_o(fault_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; int seq; int rep; } ent_t;
    ent_t hist[$];
    bit         m_valid, m_last_vld, m_lockrep, m_fault;
    logic [7:0] m_data;
    int         m_last_seq, m_since;
    bit         last_acc;
    int         ntests = 0, nfail = 0;
    int         obs_hs, obs_fault, obs_lock;
    logic [7:0] obs_hs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        hist.delete();
        m_valid = 0; m_data = '0; m_last_vld = 0; m_last_seq = 0;
        m_lockrep = 0; m_since = LT; m_fault = 0;
    endtask

    task automatic clr_obs();
        obs_hs = 0; obs_fault = 0; obs_lock = 0; obs_hs_data = '0;
    endtask

    // One clock: check outputs against the model, advance the model, clock.
    task automatic cyc();
        bit acc, ld, nf, all3;
        bit exp_ready;
        ent_t e;
        logic [7:0] ldd;
        int lds, mask;
        #2;
        acc = 0;
        if (!en) begin
            chk("pt_valid", valid_o, vi);
            chk("pt_data", data_o, di);
            chk("pt_ready", ready_o, rdy);
            chk("pt_lock", lock_o, 0);
            chk("pt_fault", fault_o, 0);
            m_reset();
        end else begin
            exp_ready = !m_valid || rdy;
            chk("ready", ready_o, exp_ready);
            chk("valid", valid_o, m_valid);
            chk("lock", lock_o, (m_lockrep && m_since < LT));
            chk("fault", fault_o, m_fault);
            if (m_valid) chk("data", data_o, m_data);
            if (valid_o === 1'b1 && rdy) begin obs_hs++; obs_hs_data = data_o; end
            if (fault_o === 1'b1) obs_fault++;
            if (lock_o === 1'b1) obs_lock++;
            acc = vi && exp_ready;
            ld = 0; nf = 0; ldd = '0; lds = 0;
            if (acc) begin
                e.d = di; e.seq = int'(idi >> 2); e.rep = int'(idi & 5'h3);
                hist.push_front(e);
                if (hist.size() > 3) void'(hist.pop_back());
                for (int i = 0; i < hist.size(); i++)
                    for (int j = i + 1; j < hist.size(); j++)
                        if (!ld && hist[i].seq == hist[j].seq && hist[i].d == hist[j].d) begin
                            ld = 1; ldd = hist[i].d; lds = hist[i].seq;
                        end
                if (ld && m_last_vld && lds == m_last_seq) ld = 0;
                if (e.rep == 2) begin
                    all3 = (hist.size() == 3);
                    mask = 0;
                    foreach (hist[k]) begin
                        mask |= (1 << hist[k].rep);
                        if (hist[k].seq != e.seq || hist[k].d != e.d) all3 = 0;
                    end
                    nf = !(all3 && mask == 7);
                end
                m_since = 0; m_lockrep = (e.rep != 2);
            end else if (m_since < LT) begin
                m_since++;
                if (m_since == LT && m_lockrep) nf = 1;
            end
            m_fault = nf;
            if (ld) begin
                m_valid = 1; m_data = ldd; m_last_vld = 1; m_last_seq = lds;
            end else if (m_valid && rdy) m_valid = 0;
        end
        last_acc = acc;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [4:0] id);
        bit done = 0;
        vi = 1; di = d; idi = id;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc();
            done = last_acc;
        end
        if (!done) chk("send_timeout", 0, 1);
        vi = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic gap();
        en = 0; vi = 0; cyc(); en = 1; clr_obs();
    endtask

    initial begin
        m_reset(); clr_obs();
        // Reset state
        #3;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_lock", lock_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_ready", ready_o, 1);
        @(posedge clk); #1; rst_n = 1;
        rdy = 1;
        idle(2);

        // Clean triplet
        clr_obs();
        send(8'hA5, 5'h04); send(8'hA5, 5'h05); send(8'hA5, 5'h06);
        idle(3);
        chk("t1_hs", obs_hs, 1);
        chk("t1_data", obs_hs_data, 8'hA5);
        chk("t1_fault", obs_fault, 0);
        chk("t1_lock_end", lock_o, 0);

        // One corrupted copy
        gap();
        send(8'h3C, 5'h08); send(8'h7C, 5'h09); send(8'h3C, 5'h0A);
        idle(3);
        chk("t2_hs", obs_hs, 1);
        chk("t2_data", obs_hs_data, 8'h3C);
        chk("t2_fault", obs_fault, 1);

        // Missing third replica: timeout
        gap();
        send(8'h11, 5'h0C); send(8'h11, 5'h0D);
        obs_lock = 0; obs_fault = 0;
        idle(LT + 4);
        chk("t3_hs", obs_hs, 1);
        chk("t3_data", obs_hs_data, 8'h11);
        chk("t3_lock_cycles", obs_lock, LT);
        chk("t3_fault", obs_fault, 1);

        // Duplicate replica in a triplet
        gap();
        send(8'h22, 5'h0C); send(8'h22, 5'h0D); send(8'h22, 5'h0D); send(8'h22, 5'h0E);
        idle(3);
        chk("t4_hs", obs_hs, 1);
        chk("t4_data", obs_hs_data, 8'h22);

        // Downstream stall
        gap();
        rdy = 0;
        send(8'h5A, 5'h10); send(8'h5A, 5'h11);
        vi = 1; di = 8'h5A; idi = 5'h12;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t5_ready_low", ready_o, 0);
            chk("t5_data_hold", data_o, 8'h5A);
        end
        rdy = 1;
        cyc(); vi = 0;
        idle(3);
        chk("t5_hs", obs_hs, 1);

        // Reset mid-triplet discards the partial element
        gap();
        send(8'h55, 5'h14);
        rst_n = 0; #2;
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_lock", lock_o, 0);
        m_reset();
        @(posedge clk); #1; rst_n = 1;
        clr_obs();
        send(8'h55, 5'h15);
        idle(LT + 2);
        chk("t6_hs", obs_hs, 0);

        // Randomized traffic, enabled
        gap();
        for (int k = 0; k < 400; k++) begin
            vi  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            di  = 8'($urandom_range(0, 2));
            idi = 5'(($urandom_range(0, 7) << 2) | $urandom_range(0, 2));
            cyc();
        end
        vi = 0; rdy = 1;
        idle(LT + 2);

        // Randomized traffic, disabled (pass-through)
        en = 0;
        for (int k = 0; k < 60; k++) begin
            vi  = 1'($urandom);
            rdy = 1'($urandom);
            di  = 8'($urandom);
            idi = 5'($urandom_range(0, 31));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
